// File: rtl/n1_ir_queue_if.sv
// Bundle between the program bus, the N1 flow control and the instruction queue.
// Signal names keep their block-relative direction suffixes (_i into the queue, _o out of it).
// The queue side uses the slave modport; the sequencer/bench side uses master.
interface n1_ir_queue_if #(
  parameter int IW     = 16,
  parameter int HDEPTH = 4
);
  localparam int CW = $clog2(HDEPTH + 1);

  logic [IW-1:0] pbus_dat_i;
  logic          fc_ir_capture_i;
  logic          fc_ir_hoard_i;
  logic          fc_ir_expend_i;
  logic          fc_ir_flush_i;

  logic [IW-1:0] ir_cur_o;
  logic [CW-1:0] ir_hoard_cnt_o;
  logic          ir_hoard_empty_o;
  logic          ir_hoard_full_o;
  logic          ir_ovf_o;
  logic          ir_unf_o;
  logic [IW-1:0] prb_ir_cur_o;
  logic [IW-1:0] prb_ir_hoard_o;

  modport slave (
    input  pbus_dat_i, fc_ir_capture_i, fc_ir_hoard_i, fc_ir_expend_i, fc_ir_flush_i,
    output ir_cur_o, ir_hoard_cnt_o, ir_hoard_empty_o, ir_hoard_full_o,
           ir_ovf_o, ir_unf_o, prb_ir_cur_o, prb_ir_hoard_o
  );

  modport master (
    output pbus_dat_i, fc_ir_capture_i, fc_ir_hoard_i, fc_ir_expend_i, fc_ir_flush_i,
    input  ir_cur_o, ir_hoard_cnt_o, ir_hoard_empty_o, ir_hoard_full_o,
           ir_ovf_o, ir_unf_o, prb_ir_cur_o, prb_ir_hoard_o
  );
endinterface

// File: rtl/n1_ir_queue.sv
// Current instruction register plus an HDEPTH-entry hoard FIFO fed from the program bus.
// Latency: one cycle from any request to every output; all outputs come straight from flops.
// No backpressure: a hoard into a full FIFO is dropped and flagged (sticky ovf), expend on empty flags unf.
module n1_ir_queue #(
  parameter int            IW     = 16,
  parameter int            HDEPTH = 4,
  parameter logic [IW-1:0] RST_IR = '0
) (
  input logic            clk_i,
  input logic            sync_rst_i,
  n1_ir_queue_if.slave   q
);
  localparam int CW = $clog2(HDEPTH + 1);
  localparam int PW = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;

  logic [IW-1:0] mem_q [HDEPTH];
  logic [IW-1:0] ir_q, ir_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          mem_we;
  logic          empty;
  logic          full;

  // Depth need not be a power of two, so pointers wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(HDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(HDEPTH));

  // Next-state: flush wins, then bypass, pop (with optional refill), underflow, and finally capture/push.
  always_comb begin
    ir_d   = ir_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    mem_we = 1'b0;
    if (q.fc_ir_flush_i) begin
      ir_d  = RST_IR;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (q.fc_ir_expend_i && q.fc_ir_hoard_i && empty) begin
      // Bus word goes straight to the IR; nothing ever lands in the FIFO.
      ir_d = q.pbus_dat_i;
    end else if (q.fc_ir_expend_i && !empty) begin
      ir_d = mem_q[rd_q];
      rd_d = ptr_inc(rd_q);
      if (q.fc_ir_hoard_i) begin
        // Pop frees a slot this cycle, so a refill is legal even when full.
        mem_we = 1'b1;
        wr_d   = ptr_inc(wr_q);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (q.fc_ir_expend_i) begin
      unf_d = 1'b1;
      if (q.fc_ir_capture_i) ir_d = q.pbus_dat_i;
    end else begin
      if (q.fc_ir_capture_i) ir_d = q.pbus_dat_i;
      if (q.fc_ir_hoard_i) begin
        if (!full) begin
          mem_we = 1'b1;
          wr_d   = ptr_inc(wr_q);
          cnt_d  = cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      ir_q  <= RST_IR;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // FIFO storage is never cleared; reset and flush only rewind the pointers.
  always_ff @(posedge clk_i) begin
    if (mem_we && !sync_rst_i) mem_q[wr_q] <= q.pbus_dat_i;
  end

  assign q.ir_cur_o         = ir_q;
  assign q.prb_ir_cur_o     = ir_q;
  assign q.ir_hoard_cnt_o   = cnt_q;
  assign q.ir_hoard_empty_o = empty;
  assign q.ir_hoard_full_o  = full;
  assign q.ir_ovf_o         = ovf_q;
  assign q.ir_unf_o         = unf_q;
  assign q.prb_ir_hoard_o   = empty ? '0 : mem_q[rd_q];

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (sync_rst_i)
    cnt_q <= CW'(HDEPTH));
  a_not_empty_full: assert property (@(posedge clk_i) disable iff (sync_rst_i)
    !(empty && full));
  a_ptr_cnt: assert property (@(posedge clk_i) disable iff (sync_rst_i)
    ((int'(wr_q) + HDEPTH - int'(rd_q)) % HDEPTH) == (int'(cnt_q) % HDEPTH));
endmodule

// File: tb/tb_n1_ir_queue.sv
// Self-checking bench for n1_ir_queue: directed scenarios plus random traffic against a queue model.
// Inputs change #1 after the rising edge; outputs are sampled at that same point, one cycle after the request.
// The model keeps the hoard as a plain SV queue and applies the request rules directly.
module tb_n1_ir_queue;
  localparam int IW = 16;
  localparam int HD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  n1_ir_queue_if #(.IW(IW), .HDEPTH(HD)) qif ();

  n1_ir_queue #(.IW(IW), .HDEPTH(HD), .RST_IR(16'h0000)) dut (
    .clk_i      (clk),
    .sync_rst_i (rst),
    .q          (qif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [IW-1:0] m_ir;
  logic [IW-1:0] m_q[$];
  logic          m_ovf;
  logic          m_unf;

  task automatic model_step(input logic r, input logic cap, input logic hrd,
                            input logic exp, input logic fl, input logic [IW-1:0] dat);
    if (r || fl) begin
      m_ir = 16'h0000; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (exp) begin
      if (m_q.size() == 0) begin
        if (hrd) m_ir = dat;
        else begin
          m_unf = 1'b1;
          if (cap) m_ir = dat;
        end
      end else begin
        m_ir = m_q.pop_front();
        if (hrd) m_q.push_back(dat);
      end
    end else begin
      if (cap) m_ir = dat;
      if (hrd) begin
        if (m_q.size() < HD) m_q.push_back(dat);
        else m_ovf = 1'b1;
      end
    end
  endtask

  // Apply one cycle of requests and advance the model alongside it.
  task automatic drive(input logic r, input logic cap, input logic hrd,
                       input logic exp, input logic fl, input logic [IW-1:0] dat);
    rst                 = r;
    qif.pbus_dat_i      = dat;
    qif.fc_ir_capture_i = cap;
    qif.fc_ir_hoard_i   = hrd;
    qif.fc_ir_expend_i  = exp;
    qif.fc_ir_flush_i   = fl;
    model_step(r, cap, hrd, exp, fl, dat);
    @(posedge clk);
    #1;
    rst                 = 1'b0;
    qif.fc_ir_capture_i = 1'b0;
    qif.fc_ir_hoard_i   = 1'b0;
    qif.fc_ir_expend_i  = 1'b0;
    qif.fc_ir_flush_i   = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    n_tests++; if (qif.ir_cur_o !== 16'h0000) begin n_fail++; $display("FAIL reset_ir got %h exp 0000", qif.ir_cur_o); end
    n_tests++; if (qif.ir_hoard_cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", qif.ir_hoard_cnt_o); end
    n_tests++; if (qif.ir_hoard_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", qif.ir_hoard_empty_o); end
    n_tests++; if (qif.ir_hoard_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", qif.ir_hoard_full_o); end
    n_tests++; if (qif.ir_ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", qif.ir_ovf_o); end
    n_tests++; if (qif.ir_unf_o !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b exp 0", qif.ir_unf_o); end
    n_tests++; if (qif.prb_ir_hoard_o !== 16'h0000) begin n_fail++; $display("FAIL reset_prb got %h exp 0000", qif.prb_ir_hoard_o); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA000 + 16'(i));
      if (i == 4) begin
        n_tests++; if (qif.ir_hoard_cnt_o !== 3'd4) begin n_fail++; $display("FAIL fill_cnt got %0d exp 4", qif.ir_hoard_cnt_o); end
        n_tests++; if (qif.ir_hoard_full_o !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", qif.ir_hoard_full_o); end
        n_tests++; if (qif.ir_ovf_o !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early got %b exp 0", qif.ir_ovf_o); end
      end
    end
    n_tests++; if (qif.ir_ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", qif.ir_ovf_o); end
    n_tests++; if (qif.ir_hoard_cnt_o !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 4", qif.ir_hoard_cnt_o); end
    n_tests++; if (qif.prb_ir_hoard_o !== 16'hA001) begin n_fail++; $display("FAIL ovf_prb got %h exp A001", qif.prb_ir_hoard_o); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
      n_tests++; if (qif.ir_cur_o !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL drain_ir%0d got %h exp %h", i, qif.ir_cur_o, 16'hA000 + 16'(i)); end
    end
    n_tests++; if (qif.ir_hoard_empty_o !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", qif.ir_hoard_empty_o); end
    n_tests++; if (qif.ir_unf_o !== 1'b0) begin n_fail++; $display("FAIL drain_unf_early got %b exp 0", qif.ir_unf_o); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    n_tests++; if (qif.ir_unf_o !== 1'b1) begin n_fail++; $display("FAIL unf_set got %b exp 1", qif.ir_unf_o); end
    n_tests++; if (qif.ir_cur_o !== 16'hA004) begin n_fail++; $display("FAIL unf_ir got %h exp A004", qif.ir_cur_o); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    // Offset the pointers first so the full push/pop also exercises wrap.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0EEE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hD000 + 16'(i));
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hB000);
    n_tests++; if (qif.ir_cur_o !== 16'hD000) begin n_fail++; $display("FAIL pp_ir got %h exp D000", qif.ir_cur_o); end
    n_tests++; if (qif.ir_hoard_cnt_o !== 3'd4) begin n_fail++; $display("FAIL pp_cnt got %0d exp 4", qif.ir_hoard_cnt_o); end
    n_tests++; if (qif.ir_ovf_o !== 1'b0) begin n_fail++; $display("FAIL pp_ovf got %b exp 0", qif.ir_ovf_o); end
    for (int i = 0; i < 4; i++) begin
      logic [IW-1:0] exp_ir;
      exp_ir = (i == 3) ? 16'hB000 : 16'hD001 + 16'(i);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      n_tests++; if (qif.ir_cur_o !== exp_ir) begin n_fail++; $display("FAIL pp_drain%0d got %h exp %h", i, qif.ir_cur_o, exp_ir); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hC0DE);
    n_tests++; if (qif.ir_cur_o !== 16'hC0DE) begin n_fail++; $display("FAIL bypass_ir got %h exp C0DE", qif.ir_cur_o); end
    n_tests++; if (qif.ir_hoard_cnt_o !== 3'd0) begin n_fail++; $display("FAIL bypass_cnt got %0d exp 0", qif.ir_hoard_cnt_o); end
    n_tests++; if (qif.ir_unf_o !== 1'b1) begin n_fail++; $display("FAIL bypass_unf got %b exp 1 (kept)", qif.ir_unf_o); end
  endtask

  task automatic test_priority;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5678);
    n_tests++; if (qif.ir_cur_o !== 16'h1234) begin n_fail++; $display("FAIL prio_ir got %h exp 1234", qif.ir_cur_o); end
    n_tests++; if (qif.ir_hoard_cnt_o !== 3'd0) begin n_fail++; $display("FAIL prio_cnt got %0d exp 0", qif.ir_hoard_cnt_o); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5678);
    n_tests++; if (qif.ir_cur_o !== 16'h5678) begin n_fail++; $display("FAIL capture_ir got %h exp 5678", qif.ir_cur_o); end
    n_tests++; if (qif.ir_unf_o !== 1'b0) begin n_fail++; $display("FAIL prio_unf got %b exp 0", qif.ir_unf_o); end
  endtask

  task automatic test_flush;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7000 + 16'(i));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    n_tests++; if (qif.ir_hoard_cnt_o !== 3'd3 || qif.ir_ovf_o !== 1'b1) begin n_fail++; $display("FAIL flush_setup got cnt=%0d ovf=%b exp cnt=3 ovf=1", qif.ir_hoard_cnt_o, qif.ir_ovf_o); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    n_tests++; if (qif.ir_cur_o !== 16'h0000) begin n_fail++; $display("FAIL flush_ir got %h exp 0000", qif.ir_cur_o); end
    n_tests++; if (qif.ir_hoard_cnt_o !== 3'd0) begin n_fail++; $display("FAIL flush_cnt got %0d exp 0", qif.ir_hoard_cnt_o); end
    n_tests++; if (qif.ir_ovf_o !== 1'b0 || qif.ir_unf_o !== 1'b0) begin n_fail++; $display("FAIL flush_flags got ovf=%b unf=%b exp 0 0", qif.ir_ovf_o, qif.ir_unf_o); end
    n_tests++; if (qif.prb_ir_hoard_o !== 16'h0000) begin n_fail++; $display("FAIL flush_prb got %h exp 0000", qif.prb_ir_hoard_o); end
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      logic r, fl, cap, hrd, exp;
      logic [IW-1:0] dat, m_prb;
      r   = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      cap = $urandom_range(0, 1) == 1;
      hrd = $urandom_range(0, 99) < 55;
      exp = $urandom_range(0, 99) < 40;
      dat = 16'($urandom);
      drive(r, cap, hrd, exp, fl, dat);
      m_prb = (m_q.size() != 0) ? m_q[0] : 16'h0000;
      n_tests++;
      if (qif.ir_cur_o !== m_ir || qif.prb_ir_cur_o !== m_ir ||
          qif.ir_hoard_cnt_o !== 3'(m_q.size()) ||
          qif.ir_hoard_empty_o !== (m_q.size() == 0) ||
          qif.ir_hoard_full_o !== (m_q.size() == HD) ||
          qif.ir_ovf_o !== m_ovf || qif.ir_unf_o !== m_unf ||
          qif.prb_ir_hoard_o !== m_prb) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand_c%0d got ir=%h cnt=%0d e=%b f=%b ovf=%b unf=%b prb=%h exp ir=%h cnt=%0d ovf=%b unf=%b prb=%h",
                   c, qif.ir_cur_o, qif.ir_hoard_cnt_o, qif.ir_hoard_empty_o, qif.ir_hoard_full_o,
                   qif.ir_ovf_o, qif.ir_unf_o, qif.prb_ir_hoard_o,
                   m_ir, m_q.size(), m_ovf, m_unf, m_prb);
      end
    end
  endtask

  initial begin
    qif.pbus_dat_i      = '0;
    qif.fc_ir_capture_i = 1'b0;
    qif.fc_ir_hoard_i   = 1'b0;
    qif.fc_ir_expend_i  = 1'b0;
    qif.fc_ir_flush_i   = 1'b0;
    #1;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_back_to_back();
    test_priority();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
